fpu_sched: RTL and testbench

Round-robin scheduler that shares one fully pipelined, fixed-latency FPU among NUM_REQ requesters. It accepts operations over per-requester valid/ready handshakes and issues at most one operation per cycle to the FPU. It tags each in-flight operation with its requester id and returns each result to the requester that issued it. A drain control lets the testbench or system stop new issue and wait for the pipeline to empty, for example before reset or reconfiguration.

---
 rtl/fpu_sched.sv | 218 +++++++++++++++++++++
 tb/tb_fpu_sched.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_sched.sv
// fpu_sched: round-robin scheduler that shares one fully pipelined,
// fixed-latency FPU among NUM_REQ requesters. Each issued op carries its
// requester id down a tag pipe that lines up with the FPU result, so the
// result is returned to the requester that sent it.
//
// Optional build macro: FPU_SCHED_STATS_EN adds stat_issued (per-requester
// accepted-op counters) and stat_inflight (ops accepted but not yet answered).
//
// Handshake: a requester transfer happens on a rising clk edge where
// req_valid[i] && req_ready[i]. req_ready is combinational, one-hot or zero,
// and depends only on req_valid and internal state. Responses (rsp_valid)
// are single-cycle strobes with no back-pressure.
module fpu_sched #(
    parameter int NUM_REQ     = 4,
    parameter int FPU_LATENCY = 3,
    localparam int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [32*NUM_REQ-1:0]  req_opA,
    input  logic [32*NUM_REQ-1:0]  req_opB,
    input  logic [2*NUM_REQ-1:0]   req_op,
    input  logic                   drain_req,
    output logic                   idle,
    output logic                   fpu_issue,
    output logic [31:0]            fpu_opA,
    output logic [31:0]            fpu_opB,
    output logic [1:0]             fpu_op,
    input  logic [31:0]            fpu_out,
    output logic [NUM_REQ-1:0]     rsp_valid,
    output logic [31:0]            rsp_data,
`ifdef FPU_SCHED_STATS_EN
    output logic [32*NUM_REQ-1:0]  stat_issued,
    output logic [$clog2(FPU_LATENCY+2):0] stat_inflight,
`endif
    output logic [1:0]             dbg_state
);

    localparam logic [1:0] ST_RUN   = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_HALT  = 2'd2;

    localparam logic [ID_W-1:0] RR_INIT = ID_W'(NUM_REQ - 1);

    logic [1:0]                       state_q, state_d;
    logic [ID_W-1:0]                  rr_q, rr_d;

    logic                             iss_vld_q, iss_vld_d;
    logic [ID_W-1:0]                  iss_id_q, iss_id_d;
    logic [31:0]                      iss_a_q, iss_a_d;
    logic [31:0]                      iss_b_q, iss_b_d;
    logic [1:0]                       iss_op_q, iss_op_d;

    logic [FPU_LATENCY-1:0]           tag_vld_q, tag_vld_d;
    logic [FPU_LATENCY-1:0][ID_W-1:0] tag_id_q, tag_id_d;

    logic [NUM_REQ-1:0]               rsp_valid_q, rsp_valid_d;
    logic [31:0]                      rsp_data_q, rsp_data_d;

    logic                             grant_found;
    logic [ID_W-1:0]                  grant_id;
    logic                             accept;
    logic                             tag_exit;
    logic                             pipe_empty;

    // Round-robin search: first valid requester after the last one granted.
    always_comb begin
        grant_found = 1'b0;
        grant_id    = rr_q;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (!grant_found && req_valid[(int'(rr_q) + k) % NUM_REQ]) begin
                grant_found = 1'b1;
                grant_id    = ID_W'((int'(rr_q) + k) % NUM_REQ);
            end
        end
    end

    // Ready only in RUN and out of reset, so all outputs read 0 during reset.
    always_comb begin
        req_ready = '0;
        if (reset_n && (state_q == ST_RUN) && grant_found) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    assign accept     = |(req_valid & req_ready);
    assign tag_exit   = tag_vld_q[FPU_LATENCY-1];
    assign pipe_empty = !iss_vld_q && (tag_vld_q == '0);

    // Mode control: dropping drain_req always returns to RUN first.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (drain_req) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!drain_req)      state_d = ST_RUN;
                else if (pipe_empty) state_d = ST_HALT;
            end
            ST_HALT: begin
                if (!drain_req) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Issue register, tag pipe and response register next values.
    always_comb begin
        rr_d      = accept ? grant_id : rr_q;

        iss_vld_d = accept;
        iss_id_d  = iss_id_q;
        iss_a_d   = iss_a_q;
        iss_b_d   = iss_b_q;
        iss_op_d  = iss_op_q;
        if (accept) begin
            iss_id_d = grant_id;
            iss_a_d  = req_opA[32*grant_id +: 32];
            iss_b_d  = req_opB[32*grant_id +: 32];
            iss_op_d = req_op[2*grant_id +: 2];
        end

        // Stage 0 takes the op being issued this cycle; the last stage lines
        // up with the FPU result for that op.
        tag_vld_d    = tag_vld_q;
        tag_id_d     = tag_id_q;
        tag_vld_d[0] = iss_vld_q;
        tag_id_d[0]  = iss_id_q;
        for (int k = 1; k < FPU_LATENCY; k++) begin
            tag_vld_d[k] = tag_vld_q[k-1];
            tag_id_d[k]  = tag_id_q[k-1];
        end

        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        if (tag_exit) begin
            rsp_valid_d[tag_id_q[FPU_LATENCY-1]] = 1'b1;
            rsp_data_d = fpu_out;
        end
    end

    // State, pointer, issue, tag and response registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_RUN;
            rr_q        <= RR_INIT;
            iss_vld_q   <= 1'b0;
            iss_id_q    <= '0;
            iss_a_q     <= '0;
            iss_b_q     <= '0;
            iss_op_q    <= '0;
            tag_vld_q   <= '0;
            tag_id_q    <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            iss_vld_q   <= iss_vld_d;
            iss_id_q    <= iss_id_d;
            iss_a_q     <= iss_a_d;
            iss_b_q     <= iss_b_d;
            iss_op_q    <= iss_op_d;
            tag_vld_q   <= tag_vld_d;
            tag_id_q    <= tag_id_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign fpu_issue = iss_vld_q;
    assign fpu_opA   = iss_a_q;
    assign fpu_opB   = iss_b_q;
    assign fpu_op    = iss_op_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign idle      = (state_q == ST_HALT);
    assign dbg_state = state_q;

`ifdef FPU_SCHED_STATS_EN
    localparam int INF_W = $clog2(FPU_LATENCY + 2) + 1;

    logic [NUM_REQ-1:0][31:0] stat_issued_q, stat_issued_d;
    logic [INF_W-1:0]         inflight_q, inflight_d;

    // Count accepts per requester; in-flight rises on accept, falls on response.
    always_comb begin
        stat_issued_d = stat_issued_q;
        if (accept) begin
            stat_issued_d[grant_id] = stat_issued_q[grant_id] + 32'd1;
        end
        inflight_d = inflight_q;
        case ({accept, tag_exit})
            2'b10:   inflight_d = inflight_q + INF_W'(1);
            2'b01:   inflight_d = inflight_q - INF_W'(1);
            default: inflight_d = inflight_q;
        endcase
    end

    // Statistics registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_issued_q <= '0;
            inflight_q    <= '0;
        end else begin
            stat_issued_q <= stat_issued_d;
            inflight_q    <= inflight_d;
        end
    end

    assign stat_issued   = stat_issued_q;
    assign stat_inflight = inflight_q;
`endif

endmodule

// File: tb/tb_fpu_sched.sv
// tb_fpu_sched: randomized and directed bench for fpu_sched. The FPU is a
// stand-in delay line computing a scrambling function, so every response
// value is traceable to the op that produced it. Requesters hold an op until
// it is accepted. Expected grants, issue slots and responses are derived from
// the round-robin rule and the fixed latencies as queues of due cycles.
module tb_fpu_sched;

    localparam int N = 4;
    localparam int L = 3;

    logic               clk;
    logic               reset_n;
    logic [N-1:0]       req_valid;
    logic [N-1:0]       req_ready;
    logic [32*N-1:0]    req_opA;
    logic [32*N-1:0]    req_opB;
    logic [2*N-1:0]     req_op;
    logic               drain_req;
    logic               idle;
    logic               fpu_issue;
    logic [31:0]        fpu_opA;
    logic [31:0]        fpu_opB;
    logic [1:0]         fpu_op;
    logic [31:0]        fpu_out;
    logic [N-1:0]       rsp_valid;
    logic [31:0]        rsp_data;
    logic [1:0]         dbg_state;
`ifdef FPU_SCHED_STATS_EN
    logic [32*N-1:0]    stat_issued;
    logic [$clog2(L+2):0] stat_inflight;
`endif

    fpu_sched #(.NUM_REQ(N), .FPU_LATENCY(L)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_opA   (req_opA),
        .req_opB   (req_opB),
        .req_op    (req_op),
        .drain_req (drain_req),
        .idle      (idle),
        .fpu_issue (fpu_issue),
        .fpu_opA   (fpu_opA),
        .fpu_opB   (fpu_opB),
        .fpu_op    (fpu_op),
        .fpu_out   (fpu_out),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
`ifdef FPU_SCHED_STATS_EN
        .stat_issued   (stat_issued),
        .stat_inflight (stat_inflight),
`endif
        .dbg_state (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in FPU function
    function automatic logic [31:0] fpu_fn(logic [31:0] a, logic [31:0] b, logic [1:0] op);
        return (a ^ {b[15:0], b[31:16]}) + ({30'd0, op} * 32'h9E3779B9);
    endfunction

    // Stand-in FPU: result appears L cycles after the issue cycle; garbage otherwise
    logic [31:0] fpu_pipe [L];
    always @(posedge clk) begin
        fpu_pipe[0] <= fpu_issue ? fpu_fn(fpu_opA, fpu_opB, fpu_op) : $urandom;
        for (int k = 1; k < L; k++) fpu_pipe[k] <= fpu_pipe[k-1];
    end
    assign fpu_out = fpu_pipe[L-1];

    // Bench state
    int n_cmp;
    int n_err;
    int cyc;
    int rr;
    int mode;      // 0 run, 1 drain, 2 halt
    logic        pend [N];
    logic [31:0] a_r  [N];
    logic [31:0] b_r  [N];
    logic [1:0]  op_r [N];
    int dut_grants[$];
    int issued_m [N];

    logic [N+31:0] exp_q[$];
    int            exp_due_q[$];
    logic [65:0]   iss_q[$];
    int            iss_due_q[$];

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, want);
        end
    endtask

    // Driver tasks
    task automatic drive();
        for (int i = 0; i < N; i++) begin
            req_valid[i]         = pend[i];
            req_opA[32*i +: 32]  = a_r[i];
            req_opB[32*i +: 32]  = b_r[i];
            req_op[2*i +: 2]     = op_r[i];
        end
    endtask

    task automatic set_op(input int i);
        pend[i] = 1'b1;
        a_r[i]  = $urandom;
        b_r[i]  = $urandom;
        op_r[i] = 2'($urandom_range(3));
    endtask

    task automatic gen(input int pct);
        for (int i = 0; i < N; i++)
            if (!pend[i] && ($urandom_range(99) < pct)) set_op(i);
    endtask

    task automatic clear_model();
        exp_q.delete();
        exp_due_q.delete();
        iss_q.delete();
        iss_due_q.delete();
        rr   = N - 1;
        mode = 0;
        for (int i = 0; i < N; i++) issued_m[i] = 0;
    endtask

    task automatic rst_chk();
        check("rst_ready", req_ready, 0);
        check("rst_issue", fpu_issue, 0);
        check("rst_opA", fpu_opA, 0);
        check("rst_opB", fpu_opB, 0);
        check("rst_op", fpu_op, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_idle", idle, 0);
`ifdef FPU_SCHED_STATS_EN
        check("rst_stat_issued", stat_issued, 0);
        check("rst_stat_inflight", stat_inflight, 0);
`endif
    endtask

    // One clock cycle: drive, check at negedge, advance the reference model.
    task automatic tick();
        int g;
        logic [N-1:0] exp_ready;
        logic [N-1:0] oh;
        drive();
        @(negedge clk);
        g = -1;
        exp_ready = '0;
        if (mode == 0)
            for (int k = 1; k <= N; k++)
                if (g < 0 && pend[(rr + k) % N]) g = (rr + k) % N;
        if (g >= 0) exp_ready[g] = 1'b1;
        check("req_ready", req_ready, exp_ready);
        check("idle", idle, mode == 2);
        for (int i = 0; i < N; i++)
            if (req_ready[i] && req_valid[i]) dut_grants.push_back(i);

        if (iss_due_q.size() > 0 && iss_due_q[0] == cyc) begin
            check("fpu_issue", fpu_issue, 1);
            check("fpu_ops", {fpu_op, fpu_opA, fpu_opB}, iss_q[0]);
            void'(iss_q.pop_front());
            void'(iss_due_q.pop_front());
        end else begin
            check("fpu_issue", fpu_issue, 0);
        end

        if (exp_due_q.size() > 0 && exp_due_q[0] == cyc) begin
            check("rsp", {rsp_valid, rsp_data}, exp_q[0]);
            void'(exp_q.pop_front());
            void'(exp_due_q.pop_front());
        end else begin
            check("rsp_valid", rsp_valid, 0);
        end

`ifdef FPU_SCHED_STATS_EN
        for (int i = 0; i < N; i++)
            check("stat_issued", stat_issued[32*i +: 32], issued_m[i]);
        check("stat_inflight", stat_inflight, exp_q.size());
`endif

        if (g >= 0) begin
            rr = g;
            oh = '0;
            oh[g] = 1'b1;
            iss_q.push_back({op_r[g], a_r[g], b_r[g]});
            iss_due_q.push_back(cyc + 1);
            exp_q.push_back({oh, fpu_fn(a_r[g], b_r[g], op_r[g])});
            exp_due_q.push_back(cyc + L + 2);
            pend[g] = 1'b0;
            issued_m[g]++;
        end

        // Busy while any accepted op has not yet reached its response cycle.
        case (mode)
            0: if (drain_req) mode = 1;
            1: if (!drain_req) mode = 0; else if (exp_q.size() == 0) mode = 2;
            2: if (!drain_req) mode = 0;
            default: mode = 0;
        endcase

        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic mid_reset();
        #2 reset_n = 1'b0;
        #1;
        rst_chk();
        clear_model();
        @(posedge clk);
        @(posedge clk);
        cyc += 2;
        #2 reset_n = 1'b1;
    endtask

    // Stimulus and final report
    initial begin
        n_cmp = 0;
        n_err = 0;
        cyc   = 0;
        clear_model();
        for (int i = 0; i < N; i++) begin
            pend[i] = 1'b0; a_r[i] = '0; b_r[i] = '0; op_r[i] = '0;
        end
        drain_req = 1'b0;
        reset_n   = 1'b0;
        drive();
        #12;
        rst_chk();
        @(posedge clk);
        #2 reset_n = 1'b1;

        // Full contention: grants must rotate 0,1,2,3,0,1,2,3
        dut_grants.delete();
        for (int k = 0; k < 8; k++) begin
            gen(100);
            tick();
        end
        repeat (12) tick();
        if (dut_grants.size() >= 8) begin
            for (int k = 0; k < 8; k++) check("rr_order", dut_grants[k], k % N);
        end else begin
            check("rr_order_count", dut_grants.size(), 8);
        end

        // Single op from requester 0
        pend[0] = 1'b1;
        a_r[0]  = 32'h3F80_0000;
        b_r[0]  = 32'h4000_0000;
        op_r[0] = 2'd0;
        tick();
        repeat (7) tick();

        // Fairness after a gap: rr parked at 1, then 0 and 3 contend
        set_op(1);
        tick();
        repeat (6) tick();
        dut_grants.delete();
        set_op(0);
        set_op(3);
        tick();
        tick();
        if (dut_grants.size() >= 2) begin
            check("fair_first", dut_grants[0], 3);
            check("fair_second", dut_grants[1], 0);
        end else begin
            check("fair_count", dut_grants.size(), 2);
        end
        repeat (6) tick();

        // Drain with ops in flight, drain rising together with a request
        set_op(0);
        set_op(1);
        set_op(2);
        tick();
        tick();
        drain_req = 1'b1;
        tick();
        set_op(3);
        repeat (10) tick();
        check("drain_idle", idle, 1);
        check("drain_ready", req_ready, 0);
        drain_req = 1'b0;
        tick();
        tick();
        repeat (6) tick();

        // Drain released while the pipe is still busy
        set_op(1);
        tick();
        drain_req = 1'b1;
        tick();
        set_op(2);
        tick();
        drain_req = 1'b0;
        repeat (8) tick();

        // Reset with two ops in flight
        set_op(0);
        set_op(1);
        tick();
        tick();
        tick();
        mid_reset();
        repeat (10) tick();

`ifdef FPU_SCHED_STATS_EN
        repeat (5) begin
            set_op(2);
            tick();
        end
        repeat (8) tick();
        for (int i = 0; i < N; i++)
            check("stat_req", stat_issued[32*i +: 32], (i == 2) ? 5 : 0);
        check("stat_inflight_end", stat_inflight, 0);
`endif

        // Randomized traffic with drain episodes
        repeat (400) begin
            gen(40);
            if (!drain_req && ($urandom_range(99) < 3)) begin
                drain_req = 1'b1;
            end else if (drain_req &&
                         ((mode == 2 && $urandom_range(99) < 30) ||
                          (mode == 1 && exp_due_q.size() > 0 &&
                           exp_due_q[exp_due_q.size()-1] > cyc &&
                           $urandom_range(99) < 10))) begin
                drain_req = 1'b0;
            end
            tick();
        end
        drain_req = 1'b0;
        repeat (30) tick();
        check("sb_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
